// File: rtl/parking_gate_counter.sv
// Multi-gate parking occupancy counter: per-gate two-barrier direction FSMs
// feed a shared saturating counter with full/empty flags and reject/underflow pulses.
module parking_gate_counter #(
  parameter  int unsigned N_GATES  = 2,
  parameter  int unsigned CAPACITY = 7,
  localparam int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_GATES-1:0] sens_a,
  input  logic [N_GATES-1:0] sens_b,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic [N_GATES-1:0] car_in,
  output logic [N_GATES-1:0] car_out,
  output logic               reject_in,
  output logic               err_underflow
);

  localparam int unsigned   EW    = CNT_W + 4;
  localparam logic [EW-1:0] CAP_E = EW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_BA,
    OUT_A,
    WAIT_CLR
  } gate_state_t;

  gate_state_t        r_state [N_GATES];
  logic [CNT_W-1:0]   r_count;
  logic [N_GATES-1:0] r_car_in;
  logic [N_GATES-1:0] r_car_out;
  logic               r_reject;
  logic               r_underflow;

  logic [N_GATES-1:0] w_entry;
  logic [N_GATES-1:0] w_exit;
  logic [EW-1:0]      w_n_in;
  logic [EW-1:0]      w_n_out;
  logic [EW-1:0]      w_count_e;
  logic [EW-1:0]      w_after_out;
  logic [EW-1:0]      w_sum;
  logic [EW-1:0]      w_next;
  logic               w_underflow;
  logic               w_reject;

  // Events are decoded from the current state and this cycle's sample so the
  // counter can absorb them on the same edge the FSM returns to IDLE.
  always_comb begin
    w_entry = '0;
    w_exit  = '0;
    for (int unsigned g = 0; g < N_GATES; g++) begin
      w_entry[g] = (r_state[g] == IN_B)  && !sens_a[g] && !sens_b[g];
      w_exit[g]  = (r_state[g] == OUT_A) && !sens_a[g] && !sens_b[g];
    end
  end

  // Exits are applied before entries so a simultaneous swap at capacity is lossless.
  always_comb begin
    w_n_in  = '0;
    w_n_out = '0;
    for (int unsigned g = 0; g < N_GATES; g++) begin
      w_n_in  = w_n_in  + EW'(w_entry[g]);
      w_n_out = w_n_out + EW'(w_exit[g]);
    end
    w_count_e   = EW'(r_count);
    w_underflow = (w_n_out > w_count_e);
    w_after_out = w_underflow ? '0 : (w_count_e - w_n_out);
    w_sum       = w_after_out + w_n_in;
    w_reject    = (w_sum > CAP_E);
    w_next      = w_reject ? CAP_E : w_sum;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned g = 0; g < N_GATES; g++) begin
        r_state[g] <= WAIT_CLR;
      end
      r_count     <= '0;
      r_car_in    <= '0;
      r_car_out   <= '0;
      r_reject    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int unsigned g = 0; g < N_GATES; g++) begin
        case (r_state[g])
          IDLE: begin
            case ({sens_a[g], sens_b[g]})
              2'b10:   r_state[g] <= IN_A;
              2'b01:   r_state[g] <= OUT_B;
              2'b11:   r_state[g] <= WAIT_CLR;
              default: r_state[g] <= IDLE;
            endcase
          end
          IN_A: begin
            case ({sens_a[g], sens_b[g]})
              2'b10:   r_state[g] <= IN_A;
              2'b11:   r_state[g] <= IN_AB;
              2'b00:   r_state[g] <= IDLE;
              default: r_state[g] <= WAIT_CLR;
            endcase
          end
          IN_AB: begin
            case ({sens_a[g], sens_b[g]})
              2'b11:   r_state[g] <= IN_AB;
              2'b01:   r_state[g] <= IN_B;
              2'b10:   r_state[g] <= IN_A;
              default: r_state[g] <= IDLE;
            endcase
          end
          IN_B: begin
            case ({sens_a[g], sens_b[g]})
              2'b01:   r_state[g] <= IN_B;
              2'b00:   r_state[g] <= IDLE;
              2'b11:   r_state[g] <= IN_AB;
              default: r_state[g] <= WAIT_CLR;
            endcase
          end
          OUT_B: begin
            case ({sens_a[g], sens_b[g]})
              2'b01:   r_state[g] <= OUT_B;
              2'b11:   r_state[g] <= OUT_BA;
              2'b00:   r_state[g] <= IDLE;
              default: r_state[g] <= WAIT_CLR;
            endcase
          end
          OUT_BA: begin
            case ({sens_a[g], sens_b[g]})
              2'b11:   r_state[g] <= OUT_BA;
              2'b10:   r_state[g] <= OUT_A;
              2'b01:   r_state[g] <= OUT_B;
              default: r_state[g] <= IDLE;
            endcase
          end
          OUT_A: begin
            case ({sens_a[g], sens_b[g]})
              2'b10:   r_state[g] <= OUT_A;
              2'b00:   r_state[g] <= IDLE;
              2'b11:   r_state[g] <= OUT_BA;
              default: r_state[g] <= WAIT_CLR;
            endcase
          end
          default: begin
            if (!sens_a[g] && !sens_b[g]) r_state[g] <= IDLE;
            else                          r_state[g] <= WAIT_CLR;
          end
        endcase
      end
      r_count     <= w_next[CNT_W-1:0];
      r_car_in    <= w_entry;
      r_car_out   <= w_exit;
      r_reject    <= w_reject;
      r_underflow <= w_underflow;
    end
  end

  assign count         = r_count;
  assign full          = (r_count == CNT_W'(CAPACITY));
  assign empty         = (r_count == '0);
  assign car_in        = r_car_in;
  assign car_out       = r_car_out;
  assign reject_in     = r_reject;
  assign err_underflow = r_underflow;

endmodule

// File: doc/parking_gate_counter.md
# parking_gate_counter

Parametrised parking-occupancy counter fed by N_GATES gates, each fitted with two light barriers (outer A, inner B). A per-gate direction FSM turns barrier sequences into entry or exit events. A shared saturating occupancy counter merges all gates, applies limits, and drives full/empty flags for the barrier controller and display. It replaces the single-lane, fixed 3-bit, pulse-input counter with a configurable capacity and multiple gates, handles simultaneous events across gates, and reports rejects and underflows.

## Interface
- N_GATES, 2, number of gates; legal range 1..8.
- CAPACITY, 7, maximum occupancy; legal range 1..65535.
- CNT_W, $clog2(CAPACITY+1), localparam; width of the count.
- clk  in  1  single system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- sens_a  in  N_GATES  outer barrier per gate; 1 = blocked; already synchronised to clk.
- sens_b  in  N_GATES  inner barrier per gate; 1 = blocked; already synchronised to clk.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY; combinational from count.
- empty  out  1  count == 0; combinational from count.
- car_in  out  N_GATES  one-cycle pulse per gate on a completed entry.
- car_out  out  N_GATES  one-cycle pulse per gate on a completed exit.
- reject_in  out  1  one-cycle pulse when at least one entry was discarded by saturation.
- err_underflow  out  1  one-cycle pulse when at least one exit was discarded at zero.

## Operation
- Per-gate FSM. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR. The sensor pair is written as (a,b).
- IDLE transitions:
  - (1,0) -> IN_A.
  - (0,1) -> OUT_B.
  - (1,1) -> WAIT_CLR.
  - (0,0) stays in IDLE.
- IN_A transitions:
  - (1,0) stays in IN_A.
  - (1,1) -> IN_AB.
  - (0,0) -> IDLE (car backed out).
  - (0,1) -> WAIT_CLR.
- IN_AB transitions:
  - (1,1) stays in IN_AB.
  - (0,1) -> IN_B.
  - (1,0) -> IN_A.
  - (0,0) -> IDLE, no event.
- IN_B transitions:
  - (0,1) stays in IN_B.
  - (0,0) -> IDLE and raises an entry event.
  - (1,1) -> IN_AB.
  - (1,0) -> WAIT_CLR.
- OUT_B, OUT_BA and OUT_A mirror IN_A, IN_AB and IN_B with a and b swapped. OUT_A followed by (0,0) raises an exit event.
- WAIT_CLR: stays until (0,0), then -> IDLE. It never raises an event.
- Merge step, each cycle:
  - I = number of entry events this cycle; O = number of exit events this cycle.
  - Both are computed at width CNT_W+4.
  - Exits are applied first: t = count − O, floored at 0.
  - Entries are applied next: new = t + I, capped at CAPACITY.
- Flag pulses:
  - err_underflow = 1 iff O > count.
  - reject_in = 1 iff t + I > CAPACITY.
- car_in and car_out pulse for every detected event, including events discarded by saturation.
- count never wraps. It never exceeds CAPACITY and never goes below 0.

## Timing
- Reset (reset_n = 0 at an edge):
  - count = 0, empty = 1, full = 0.
  - car_in, car_out, reject_in and err_underflow = 0.
  - All gate FSMs go to WAIT_CLR, so a car caught mid-transit at reset is never counted.
- Reset has priority over all events in the same cycle.
- Latency from the final (0,0) sample: if that sample is taken at edge k, then after edge k count holds the new value and the matching car_in/car_out, reject_in and err_underflow are all high for exactly one cycle.
- full and empty track count in the same cycle, with no extra delay.
- A minimum valid transit is four cycles: (1,0), (1,1), (0,1), (0,0).
- A sensor state held for many cycles does not produce repeated events.
- Events from different gates in the same cycle are all merged in that cycle; none is lost or deferred.

## Test plan
- Reset, then on gate 0 drive (1,0),(1,1),(0,1),(0,0) one cycle each -> car_in[0] pulses once; count 0→1; empty drops in the same cycle.
- With count = 0, drive the exit sequence on gate 1 -> car_out[1] pulses; err_underflow pulses; count stays 0.
- Preload to CAPACITY = 7 with 7 entries, then one more entry -> car_in pulses; reject_in pulses; count stays 7; full stays 1.
- With count = 7, complete an exit on gate 0 and an entry on gate 1 in the same cycle -> count stays 7; reject_in = 0; err_underflow = 0 (exit applied first).
- Aborted or illegal sequences: (1,0),(0,0); (1,0),(1,1),(1,0),(0,0); and IDLE→(1,1)→(0,1)→(0,0) -> no events; count unchanged; FSM returns to IDLE.
- Assert reset_n = 0 while gate 0 is in IN_AB with count = 3, and hold (1,1) after release -> count = 0. Completing that transit gives no event. A fresh full sequence afterwards gives count = 1.
